// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
// alu_ctrl_pkg : shared state, opcode and ctrl-bit constants for the ALU controller
// Revision     : 1.0
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_CLR      = 4'd1;
    localparam logic [3:0] ST_LD_M     = 4'd2;
    localparam logic [3:0] ST_LD_A     = 4'd3;
    localparam logic [3:0] ST_LD_Q     = 4'd4;
    localparam logic [3:0] ST_MUL_OP   = 4'd5;
    localparam logic [3:0] ST_MUL_SH   = 4'd6;
    localparam logic [3:0] ST_DIV_SH   = 4'd7;
    localparam logic [3:0] ST_DIV_SUB  = 4'd8;
    localparam logic [3:0] ST_DIV_TEST = 4'd9;
    localparam logic [3:0] ST_DIV_Q    = 4'd10;
    localparam logic [3:0] ST_OUT_HI   = 4'd11;
    localparam logic [3:0] ST_OUT_LO   = 4'd12;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // ctrl[i] drives datapath control input ci
    localparam int C_LD_M      = 0;
    localparam int C_LD_Q      = 1;
    localparam int C_LD_A_ALU  = 2;
    localparam int C_SUB       = 3;
    localparam int C_SHIFT     = 4;
    localparam int C_CNT       = 5;
    localparam int C_SER_IN    = 6;
    localparam int C_OUT_HI    = 7;
    localparam int C_OUT_LO    = 8;
    localparam int C_LD_A      = 9;
    localparam int C_FORCE_Q0  = 10;

    localparam int CTRL_W = 11;

endpackage : alu_ctrl_pkg

`default_nettype wire

// File: rtl/alu_control_unit.sv
// ============================================================================
// alu_control_unit : sequencer for the byte-serial add/sub/Booth-mul/restoring-div
//                    datapath. Optional macro: ALU_CTRL_DIV0_CHECK_EN.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module alu_control_unit
    import alu_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          op_in,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                done,
    output logic                err,
    output logic [1:0]          op,
    output logic [CTRL_W-1:0]   ctrl,
    output logic                internal_rst,
    input  logic                cnt_done,
    input  logic                q0,
    input  logic                qm1,
    input  logic                a7
);

    logic [3:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CTRL_W-1:0]  ctrl_w;
    logic               in_ready_w;
    logic               out_valid_w;
    logic               internal_rst_w;

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        neg_d          = neg_q;
        err_d          = err_q;
        done_d         = 1'b0;
        ctrl_w         = '0;
        in_ready_w     = 1'b0;
        out_valid_w    = 1'b0;
        internal_rst_w = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op_in;
                    err_d   = 1'b0;
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                internal_rst_w = 1'b1;
                state_d        = ST_LD_M;
            end
            ST_LD_M: begin
                in_ready_w = 1'b1;
                if (in_valid) begin
                    ctrl_w[C_LD_M] = 1'b1;
`ifdef ALU_CTRL_DIV0_CHECK_EN
                    if (op_q == OP_DIV && in == 8'h00) begin
                        err_d = 1'b1;
                    end
`endif
                    state_d = (op_q == OP_DIV) ? ST_LD_A : ST_LD_Q;
                end
            end
            ST_LD_A: begin
                in_ready_w = 1'b1;
                if (in_valid) begin
                    ctrl_w[C_LD_A] = 1'b1;
                    state_d        = ST_LD_Q;
                end
            end
            ST_LD_Q: begin
                in_ready_w = 1'b1;
                if (in_valid) begin
                    ctrl_w[C_LD_Q] = 1'b1;
                    case (op_q)
                        OP_MUL:  state_d = ST_MUL_OP;
                        // a zero divisor skips the iterations; err_q is already set
                        OP_DIV:  state_d = err_q ? ST_OUT_HI : ST_DIV_SH;
                        default: state_d = ST_OUT_HI;
                    endcase
                end
            end
            ST_MUL_OP: begin
                if (q0 && !qm1) begin
                    ctrl_w[C_LD_A_ALU] = 1'b1;
                    ctrl_w[C_SUB]      = 1'b1;
                end else if (!q0 && qm1) begin
                    ctrl_w[C_LD_A_ALU] = 1'b1;
                end
                state_d = ST_MUL_SH;
            end
            ST_MUL_SH: begin
                ctrl_w[C_SHIFT]  = 1'b1;
                ctrl_w[C_CNT]    = 1'b1;
                ctrl_w[C_SER_IN] = a7;
                state_d          = cnt_done ? ST_OUT_HI : ST_MUL_OP;
            end
            ST_DIV_SH: begin
                ctrl_w[C_SHIFT] = 1'b1;
                state_d         = ST_DIV_SUB;
            end
            ST_DIV_SUB: begin
                ctrl_w[C_LD_A_ALU] = 1'b1;
                ctrl_w[C_SUB]      = 1'b1;
                state_d            = ST_DIV_TEST;
            end
            ST_DIV_TEST: begin
                neg_d = a7;
                if (a7) begin
                    ctrl_w[C_LD_A_ALU] = 1'b1;
                end
                state_d = ST_DIV_Q;
            end
            ST_DIV_Q: begin
                ctrl_w[C_FORCE_Q0] = 1'b1;
                ctrl_w[C_CNT]      = 1'b1;
                ctrl_w[C_SER_IN]   = ~neg_q;
                state_d            = cnt_done ? ST_OUT_HI : ST_DIV_SH;
            end
            ST_OUT_HI: begin
                ctrl_w[C_OUT_HI] = 1'b1;
                out_valid_w      = 1'b1;
                if (out_ready) begin
                    state_d = ST_OUT_LO;
                end
            end
            ST_OUT_LO: begin
                ctrl_w[C_OUT_LO] = 1'b1;
                out_valid_w      = 1'b1;
                if (out_ready) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            done_q  <= done_d;
        end
    end

`ifdef ALU_CTRL_DIV0_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    logic unused_in;

    assign err_q     = 1'b0;
    assign unused_in = ^{in, err_d};
`endif

    assign busy         = (state_q != ST_IDLE);
    assign in_ready     = in_ready_w;
    assign out_valid    = out_valid_w;
    assign done         = done_q;
    assign err          = err_q;
    assign op           = op_q;
    assign ctrl         = ctrl_w;
    assign internal_rst = internal_rst_w;

endmodule : alu_control_unit

`default_nettype wire

// File: tb/tb_alu_control_unit.sv
// ============================================================================
// tb_alu_control_unit : directed bench with a behavioural datapath model
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_alu_control_unit;
    import alu_ctrl_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [1:0]         op_in;
    logic               busy;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_b;
    logic               out_valid;
    logic               out_ready;
    logic               done;
    logic               err;
    logic [1:0]         op;
    logic [CTRL_W-1:0]  ctrl;
    logic               internal_rst;
    logic               cnt_done;
    logic               q0;
    logic               qm1;
    logic               a7;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    alu_control_unit dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op_in        (op_in),
        .busy         (busy),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in           (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .done         (done),
        .err          (err),
        .op           (op),
        .ctrl         (ctrl),
        .internal_rst (internal_rst),
        .cnt_done     (cnt_done),
        .q0           (q0),
        .qm1          (qm1),
        .a7           (a7)
    );

    // Behavioural arithmetic unit driven by ctrl
    logic [7:0] dp_m, dp_a, dp_q, dp_out;
    logic       dp_qm1;
    logic [2:0] dp_cnt;

    always @(posedge clk) begin
        if (rst || internal_rst) begin
            dp_m <= 8'h00; dp_a <= 8'h00; dp_q <= 8'h00; dp_qm1 <= 1'b0; dp_cnt <= 3'd0;
        end else begin
            if (ctrl[C_LD_M]) dp_m <= in_b;
            if (ctrl[C_LD_A]) dp_a <= in_b;
            if (ctrl[C_LD_Q]) dp_q <= in_b;
            if (ctrl[C_LD_A_ALU]) dp_a <= ctrl[C_SUB] ? dp_a - dp_m : dp_a + dp_m;
            if (ctrl[C_SHIFT]) begin
                if (op == OP_MUL) {dp_a, dp_q, dp_qm1} <= {ctrl[C_SER_IN], dp_a, dp_q};
                else              {dp_a, dp_q} <= {dp_a[6:0], dp_q, ctrl[C_SER_IN]};
            end
            if (ctrl[C_FORCE_Q0]) dp_q[0] <= ctrl[C_SER_IN];
            if (ctrl[C_CNT]) dp_cnt <= dp_cnt + 3'd1;
        end
    end

    assign cnt_done = (dp_cnt == 3'd7);
    assign q0       = dp_q[0];
    assign qm1      = dp_qm1;
    assign a7       = dp_a[7];

    always_comb begin
        dp_out = 8'h00;
        if (ctrl[C_OUT_HI]) dp_out = dp_a;
        else if (ctrl[C_OUT_LO]) begin
            case (op)
                OP_ADD:  dp_out = dp_q + dp_m;
                OP_SUB:  dp_out = dp_q - dp_m;
                default: dp_out = dp_q;
            endcase
        end
    end

    typedef struct {
        logic [1:0] op;
        logic [7:0] m, a, q;
        logic [7:0] hi, lo;
        int         lat;
        int         nsh;
        logic       err;
    } vec_t;

    vec_t vt [8];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    function automatic int all_outs();
        return int'({busy, in_ready, out_valid, done, err, op, ctrl, internal_rst});
    endfunction

    // One transaction; qs/os = in_valid stall cycles in LD_Q, out_ready stall cycles in OUT_HI
    task automatic do_row(input vec_t v, input int qs, input int os, input string tag);
        logic [7:0] ops [3];
        logic [7:0] bytes [2];
        int nops, idx, cyc, lat, nb, nsh;
        bit done_seen, err_seen, infire;
        nops = (v.op == OP_DIV) ? 3 : 2;
        ops[0] = v.m;
        ops[1] = (v.op == OP_DIV) ? v.a : v.q;
        ops[2] = v.q;
        bytes[0] = 8'h00; bytes[1] = 8'h00;
        idx = 0; cyc = 0; lat = -1; nb = 0; nsh = 0; done_seen = 0; err_seen = 0;
        @(negedge clk);
        start = 1'b1;
        op_in = v.op;
        for (int k = 0; k < 300 && !done_seen; k++) begin
            if (k > 0) start = 1'b0;
            in_b      = ops[(idx < nops) ? idx : nops - 1];
            in_valid  = 1'b1;
            out_ready = 1'b1;
            if (in_ready && idx == nops - 1 && qs > 0) begin in_valid = 1'b0; qs--; end
            if (out_valid && nb == 0 && os > 0) begin out_ready = 1'b0; os--; end
            #1;
            if (!in_valid && in_ready) check({tag, "_stall_in_ctrl"}, int'(ctrl), 0);
            if (!out_ready && out_valid) check({tag, "_stall_out_ctrl"}, int'(ctrl), 32'h80);
            if (cyc == 1) begin
                check({tag, "_busy"}, int'(busy), 1);
                check({tag, "_op"}, int'(op), int'(v.op));
            end
            if (out_valid && lat < 0) lat = cyc;
            if (ctrl[C_SHIFT]) nsh++;
            if (err) err_seen = 1;
            if (done) done_seen = 1;
            infire = in_valid && in_ready;
            if (out_valid && out_ready && nb < 2) begin bytes[nb] = dp_out; nb++; end
            @(posedge clk);
            if (infire) idx++;
            cyc++;
            if (!done_seen) @(negedge clk);
        end
        check({tag, "_finished"}, int'(done_seen), 1);
        check({tag, "_hi"}, int'(bytes[0]), int'(v.hi));
        check({tag, "_lo"}, int'(bytes[1]), int'(v.lo));
        check({tag, "_latency"}, lat, v.lat);
        check({tag, "_shifts"}, nsh, v.nsh);
        check({tag, "_err"}, int'(err_seen), int'(v.err));
        @(negedge clk);
        #1;
        check({tag, "_done_pulse_idle"}, int'({done, busy}), 0);
    endtask

    task automatic reset_mid_mul();
        int idx = 0;
        int nsh = 0;
        bit hit = 0;
        bit infire;
        @(negedge clk);
        start = 1'b1; op_in = OP_MUL; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 60 && !hit; k++) begin
            if (k > 0) start = 1'b0;
            in_b = (idx == 0) ? 8'hFD : 8'h07;
            #1;
            if (ctrl[C_SHIFT]) begin
                nsh++;
                if (nsh == 4) begin rst = 1'b1; hit = 1; end
            end
            infire = in_valid && in_ready;
            @(posedge clk);
            if (infire) idx++;
            @(negedge clk);
        end
        check("rst_mid_reached", int'(hit), 1);
        #1;
        check("rst_mid_outputs", all_outs(), 0);
        rst = 1'b0;
    endtask

    initial begin
        vt[0] = '{OP_ADD, 8'h03, 8'h00, 8'h05, 8'h00, 8'h08, 4, 0, 1'b0};
        vt[1] = '{OP_SUB, 8'h03, 8'h00, 8'h05, 8'h00, 8'h02, 4, 0, 1'b0};
        vt[2] = '{OP_MUL, 8'hFD, 8'h00, 8'h07, 8'hFF, 8'hEB, 20, 8, 1'b0};
        vt[3] = '{OP_MUL, 8'h02, 8'h00, 8'hFF, 8'hFF, 8'hFE, 20, 8, 1'b0};
        vt[4] = '{OP_DIV, 8'h07, 8'h00, 8'h64, 8'h02, 8'h0E, 37, 8, 1'b0};
        vt[5] = '{OP_DIV, 8'h10, 8'h00, 8'hFF, 8'h0F, 8'h0F, 37, 8, 1'b0};
`ifdef ALU_CTRL_DIV0_CHECK_EN
        vt[6] = '{OP_DIV, 8'h00, 8'h12, 8'h34, 8'h12, 8'h34, 5, 0, 1'b1};
`else
        vt[6] = '{OP_DIV, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 37, 8, 1'b0};
`endif
        vt[7] = '{OP_ADD, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 4, 0, 1'b0};

        rst = 1'b1; start = 1'b0; op_in = 2'b00; in_valid = 1'b0; in_b = 8'h00; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_outs(), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_row(vt[i], 0, 0, $sformatf("row%0d", i));
        end

        begin
            vec_t bp;
            bp = vt[0];
            bp.lat = 7;
            do_row(bp, 3, 5, "backpressure");
        end

        reset_mid_mul();
        do_row(vt[2], 0, 0, "mul_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_alu_control_unit

`default_nettype wire

// File: doc/alu_control_unit.md
ALU_CONTROL_UNIT -- requirements
Module: alu_control_unit

Interface
REQ-001 SHALL have no parameters; iteration count is fixed at 8 by the datapath 3-bit counter.
REQ-002 SHALL have port clk, input, 1: single rising-edge clock.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports start (in, 1) and op_in (in, 2): request start and opcode (00 add, 01 sub, 10 mul, 11 div).
REQ-005 SHALL have port busy, output, 1: high from start acceptance until final result handshake.
REQ-006 SHALL have ports in_valid (in, 1), in_ready (out, 1) and in (in, 8): operand byte handshake; in is observed by the controller only in the divide-by-zero check.
REQ-007 SHALL have ports out_valid (out, 1) and out_ready (in, 1): result byte handshake.
REQ-008 SHALL have ports done (out, 1: one-cycle completion pulse) and err (out, 1: divide-by-zero flag).
REQ-009 SHALL have port op, output, 2: latched opcode driven to the datapath.
REQ-010 SHALL have ports ctrl (out, 11: bit i drives datapath ci) and internal_rst (out, 1).
REQ-011 SHALL have datapath status inputs cnt_done, q0, qm1 and a7, each 1 bit.

Function
REQ-012 SHALL use states IDLE, CLR, LD_M, LD_A, LD_Q, MUL_OP, MUL_SH, DIV_SH, DIV_SUB, DIV_TEST, DIV_Q, OUT_HI, OUT_LO.
REQ-013 SHALL, in IDLE, accept start, latch op_in into op and go to CLR; start outside IDLE SHALL be ignored.
REQ-014 SHALL, in CLR, assert internal_rst for one cycle and go to LD_M.
REQ-015 SHALL, in LD_M/LD_A/LD_Q, assert in_ready and load only on in_valid&in_ready: c0 (M), c9 (A), c1 (Q); LD_A is visited for div only; order is M, A, Q.
REQ-016 SHALL, after LD_Q, go to OUT_HI for add/sub (adder result is combinational), MUL_OP for mul and DIV_SH for div.
REQ-017 SHALL, in MUL_OP, decode {q0,qm1}: 10 gives c2=1, c3=1 (A-M); 01 gives c2=1, c3=0 (A+M); 00/11 give no load; it always takes one cycle.
REQ-018 SHALL, in MUL_SH, assert c4, c5 and c6=a7 (arithmetic shift), then go to OUT_HI if cnt_done else MUL_OP.
REQ-019 SHALL, for unsigned restoring division: DIV_SH asserts c4 with c6=0; DIV_SUB asserts c2, c3=1; DIV_TEST registers neg=a7 and, if a7, asserts c2, c3=0 (restore).
REQ-020 SHALL, in DIV_Q, assert c10, c5 and c6=~neg, then go to OUT_HI if cnt_done else DIV_SH.
REQ-021 SHALL, in OUT_HI, assert c7 and out_valid, holding until out_ready; OUT_LO SHALL do the same with c8, then pulse done and return to IDLE.
REQ-022 SHALL hold all ctrl bits, except those listed for the current state, at 0.
REQ-023 SHALL stall indefinitely without error on in_valid=0 or out_ready=0.
REQ-024 SHALL give fixed latency with in_valid=1 from start-accept cycle 0: CLR at 1, first out_valid at cycle 4 (add/sub), 20 (mul) and 37 (div).

Reset
REQ-025 SHALL, on rst (including mid-operation), go to IDLE next edge with ctrl=0, internal_rst=0, busy=0, in_ready=0, out_valid=0, done=0, err=0, op=00.
REQ-026 SHALL clear err on the next accepted start.

Configuration
REQ-027 SHALL, with ALU_CTRL_DIV0_CHECK_EN defined: in LD_M for div, a byte in==0x00 sets err, and after LD_A/LD_Q iterations are skipped (straight to OUT_HI, A/Q output as loaded).
REQ-028 SHALL, without ALU_CTRL_DIV0_CHECK_EN, keep err constant 0 and leave in unused.

Structure
REQ-029 SHALL place the state enum, opcode constants and ctrl bit-index constants (C_LD_M=0 ... C_FORCE_Q0=10) in package alu_ctrl_pkg.
REQ-030 SHALL be a single module with no sub-module; it is instantiated beside arithmetic_unit.

Verification
REQ-031 SHALL cover add: M=0x03, Q=0x05 -> bytes 0x00, 0x08; out_valid first at cycle 4.
REQ-032 SHALL cover Booth mul: M=0xFD, Q=0x07 -> 0xFF, 0xEB; exactly 8 MUL_SH cycles, first out_valid at cycle 20.
REQ-033 SHALL cover div: M=0x07, A=0x00, Q=0x64 -> remainder 0x02, quotient 0x0E; first out_valid at cycle 37.
REQ-034 SHALL cover backpressure: in_valid low for 3 cycles in LD_Q and out_ready low for 5 cycles in OUT_HI -> stall with ctrl stable, same result.
REQ-035 SHALL cover reset mid-operation: rst during the 4th MUL_SH -> IDLE with all outputs 0; the next mul is correct.
REQ-036 SHALL cover ALU_CTRL_DIV0_CHECK_EN: div with M=0x00 -> err=1, no DIV_* states, first out_valid at cycle 5.
